// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped instruction cache: zero-latency hits, 4-word block refill
// from slow_memory over a read/ready handshake. Write side is tied inactive.
module icache_direct_mapped #(
    parameter int NUM_LINES = 8,
    parameter int INDEX_W   = 3,
    parameter int TAG_W     = 30 - 2 - INDEX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          proc_read,
    input  logic [29:0]   proc_addr,
    output logic [31:0]   proc_rdata,
    output logic          proc_stall,
    output logic          mem_read,
    output logic          mem_write,
    output logic [27:0]   mem_addr,
    output logic [127:0]  mem_wdata,
    input  logic [127:0]  mem_rdata,
    input  logic          mem_ready
);

    // state  | meaning
    // IDLE   | serve hits; a miss latches the block address
    // ALLOC  | mem_read held high until mem_ready installs the block
    // FILL   | one settling cycle before the held request hits in IDLE
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  mem_read_q, mem_read_d;
    logic [27:0]           mem_addr_q, mem_addr_d;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [127:0]          data_q [NUM_LINES];

    logic [1:0]            req_offset;
    logic [INDEX_W-1:0]    req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic [127:0]          line_data;
    logic                  hit;
    logic                  fill_en;
    logic                  stall;
    logic [31:0]           rdata;

    assign req_offset = proc_addr[1:0];
    assign req_index  = proc_addr[INDEX_W+1:2];
    assign req_tag    = proc_addr[29:INDEX_W+2];

    // The refill targets the line latched at the miss, never the live request address.
    assign fill_index = mem_addr_q[INDEX_W-1:0];
    assign fill_tag   = mem_addr_q[27:INDEX_W];

    assign line_data = data_q[req_index];
    assign hit       = proc_read & valid_q[req_index] & (tag_q[req_index] == req_tag);

    always_comb begin
        state_d    = state_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        fill_en    = 1'b0;
        stall      = 1'b0;
        rdata      = 32'd0;
        unique case (state_q)
            S_IDLE: begin
                if (proc_read) begin
                    if (hit) begin
                        rdata = line_data[{req_offset, 5'd0} +: 32];
                    end else begin
                        stall      = 1'b1;
                        mem_addr_d = {req_tag, req_index};
                        mem_read_d = 1'b1;
                        state_d    = S_ALLOC;
                    end
                end
            end
            S_ALLOC: begin
                stall = 1'b1;
                if (mem_ready) begin
                    fill_en    = 1'b1;
                    mem_read_d = 1'b0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                stall   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                mem_read_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_read_q <= 1'b0;
            mem_addr_q <= 28'd0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            if (fill_en) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= mem_rdata;
        end
    end

    // A request held during reset must not report a stall.
    assign proc_stall = stall & rst_n;
    assign proc_rdata = rdata;
    assign mem_read   = mem_read_q;
    assign mem_addr   = mem_addr_q;
    assign mem_write  = 1'b0;
    assign mem_wdata  = 128'd0;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: misses, hits, eviction, reset mid-fill,
// withdrawn request and idle tie-offs, checked with immediate assertions.
module tb_icache_direct_mapped;

    logic          clk;
    logic          rst_n;
    logic          proc_read;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_rdata;
    logic          proc_stall;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] BLK_A = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] BLK_B = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [127:0] BLK_C = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [127:0] BLK_D = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;

    icache_direct_mapped dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    // Runs one miss: request cycle, lat cycles of ALLOC (mem_ready in the last),
    // one FILL cycle, then the IDLE cycle where the held request should hit.
    task automatic serve_miss(input logic [29:0] addr, input logic [27:0] exp_baddr,
                              input logic [127:0] blk, input int lat, input bit drop,
                              input logic [31:0] exp_word);
        int stall_cycles;
        int rd_cycles;
        tick();
        proc_read = 1'b1;
        proc_addr = addr;
        #1;
        chk("miss_stall", proc_stall, 1);
        chk("miss_memrd_low", mem_read, 0);
        stall_cycles = 1;
        rd_cycles    = 0;
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (drop && k == 1) proc_read = 1'b0;
            if (k == lat) begin
                mem_ready = 1'b1;
                mem_rdata = blk;
            end
            #1;
            chk("alloc_memrd", mem_read, 1);
            chk("alloc_memaddr", mem_addr, exp_baddr);
            chk("alloc_stall", proc_stall, 1);
            if (proc_stall) stall_cycles++;
            if (mem_read) rd_cycles++;
        end
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        chk("fill_memrd", mem_read, 0);
        chk("fill_stall", proc_stall, 1);
        if (proc_stall) stall_cycles++;
        tick();
        chk("stall_cycles", stall_cycles, lat + 2);
        chk("memrd_cycles", rd_cycles, lat);
        chk("served_stall", proc_stall, 0);
        chk("served_rdata", proc_rdata, drop ? 32'd0 : exp_word);
        chk("served_memrd", mem_read, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        proc_read = 1'b1;
        proc_addr = 30'h5;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #12;
        chk("rst_stall", proc_stall, 0);
        chk("rst_memrd", mem_read, 0);
        chk("rst_memaddr", mem_addr, 0);
        chk("rst_rdata", proc_rdata, 0);
        chk("rst_memwr", mem_write, 0);
        chk("rst_wdata", mem_wdata, 0);
        proc_read = 1'b0;
        rst_n = 1'b1;

        // Cold miss: 10-cycle memory, word1 of block 1.
        serve_miss(30'h5, 28'h1, BLK_A, 10, 1'b0, 32'h22);

        // Hits on the freshly filled line.
        tick();
        proc_addr = 30'h4;
        #1;
        chk("hit4_stall", proc_stall, 0);
        chk("hit4_rdata", proc_rdata, 32'h11);
        chk("hit4_memrd", mem_read, 0);
        tick();
        proc_addr = 30'h7;
        #1;
        chk("hit7_stall", proc_stall, 0);
        chk("hit7_rdata", proc_rdata, 32'h44);
        chk("hit7_memrd", mem_read, 0);

        // Conflict eviction on index 1.
        tick();
        proc_read = 1'b0;
        do_reset();
        serve_miss(30'h5,  28'h1, BLK_A, 4, 1'b0, 32'h22);
        serve_miss(30'h25, 28'h9, BLK_B, 3, 1'b0, 32'hB1B1B1B1);
        serve_miss(30'h5,  28'h1, BLK_A, 2, 1'b0, 32'h22);

        // Reset mid-fill abandons the line.
        tick();
        proc_read = 1'b1;
        proc_addr = 30'h10;
        tick();
        tick();
        tick();
        chk("pre_rst_memrd", mem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_memrd", mem_read, 0);
        chk("midrst_stall", proc_stall, 0);
        chk("midrst_memaddr", mem_addr, 0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("postrst_miss", proc_stall, 1);
        proc_read = 1'b0;
        #1;
        chk("postrst_idle", proc_stall, 0);
        serve_miss(30'h10, 28'h4, BLK_C, 2, 1'b0, 32'hC0C0C0C0);

        // Withdrawn request still installs the line.
        serve_miss(30'h40, 28'h10, BLK_D, 5, 1'b1, 32'h0);
        tick();
        proc_read = 1'b1;
        proc_addr = 30'h42;
        #1;
        chk("wd_hit_stall", proc_stall, 0);
        chk("wd_hit_rdata", proc_rdata, 32'hD2D2D2D2);

        // Idle with a stray mem_ready, then confirm contents untouched.
        for (int i = 0; i < 20; i++) begin
            tick();
            proc_read = 1'b0;
            mem_ready = (i == 0);
            mem_rdata = {4{32'hDEADBEEF}};
            #1;
            chk("idle_stall", proc_stall, 0);
            chk("idle_memrd", mem_read, 0);
            chk("idle_memwr", mem_write, 0);
            chk("idle_wdata", mem_wdata, 0);
        end
        mem_ready = 1'b0;
        tick();
        proc_read = 1'b1;
        proc_addr = 30'h10;
        #1;
        chk("keep_c_stall", proc_stall, 0);
        chk("keep_c_rdata", proc_rdata, 32'hC0C0C0C0);
        tick();
        proc_addr = 30'h43;
        #1;
        chk("keep_d_stall", proc_stall, 0);
        chk("keep_d_rdata", proc_rdata, 32'hD3D3D3D3);
        tick();
        proc_addr = 30'h5;
        #1;
        chk("gone_a_stall", proc_stall, 1);
        proc_read = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
